ias_param_memory: RTL and testbench
===================================

# ias_param_memory

Parametrised single-port data memory for the IAS datapath, successor to the fixed 16x8 store. It has configurable word width, depth and read latency, and a valid/ready request handshake. After reset it runs a hardware clear sweep, so contents are defined before first use. Read data returns on a pipelined response channel, and a compile-time option adds per-word parity checking.

## Interface
- DATA_W, 8: data word width in bits, 1..64.
- ADDR_W, 4: address width in bits.
- DEPTH, 16: number of words, 2..2**ADDR_W; need not be a power of two.
- RD_LAT, 1: read latency from request acceptance to response, 1..4 cycles.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read; sampled on acceptance.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_perr_inj  in  1  invert stored parity on this write; ignored without MEM_PARITY_EN.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_rdata  out  DATA_W  read data; holds its last value when rsp_valid=0.
- rsp_perr  out  1  parity mismatch on this response; constant 0 without MEM_PARITY_EN.
- init_done  out  1  clear sweep complete.

## Operation
- FSM states: INIT, RUN.
- rst_n low:
  - State goes to INIT, clear counter goes to 0.
  - Read pipeline is flushed.
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_perr=0, init_done=0.
  - Array contents are not reset directly.
- INIT:
  - Each clock writes 0 (with correct parity) to the word at the counter, then increments the counter.
  - After word DEPTH-1 is written, go to RUN.
  - req_ready=0 throughout INIT.
- RUN:
  - req_ready=1 and init_done=1.
  - A request is accepted when req_valid && req_ready.
  - The only way back to INIT is reset.
- Write:
  - Array updates at the accepting edge.
  - No response is generated.
- Read:
  - Array is sampled at the accepting edge.
  - The value passes through a pipeline of RD_LAT-1 further registers.
  - No response backpressure; back-to-back reads give back-to-back rsp_valid pulses in order.
- Read after write to the same address on a later cycle returns the new data.
- Out of range, req_addr >= DEPTH:
  - Write is dropped; the array is unchanged.
  - Read returns rsp_rdata=0 with rsp_perr=0 after the normal latency.
- Reset mid-operation, including during INIT or with reads in flight:
  - In-flight responses are discarded; no rsp_valid pulse is produced.
  - INIT restarts from word 0.

## Timing
- Clear sweep: init_done and req_ready rise after exactly DEPTH rising edges following rst_n deassertion.
- Read accepted at edge N: rsp_valid=1 and rsp_rdata are registered at edge N+RD_LAT-1, visible in the cycle that follows.
  - RD_LAT=1 matches the old single-cycle read.
- Throughput: one request per cycle, any mix of reads and writes.
- A write at edge N followed by a read of the same address at edge N+1 returns the written value.

## Configuration
- Macro: MEM_PARITY_EN.
- Defined:
  - Each word stores DATA_W+1 bits; the extra bit is even parity over the data.
  - A write with req_perr_inj=1 stores inverted parity.
  - On each read response, rsp_perr = recomputed parity XOR stored parity, aligned with rsp_valid.
- Undefined:
  - Storage is DATA_W bits.
  - req_perr_inj is ignored; rsp_perr is tied to 0.

## Test plan
- Reset, then hold req_valid=1 with DATA_W=8, DEPTH=16 -> req_ready=0 for 16 cycles, init_done=1 after edge 16; reading all 16 addresses returns 0x00.
- RD_LAT=3: write 0xA5 to addr 3, then read addr 3 -> rsp_valid pulses exactly 3 edges after the read is accepted, rsp_rdata=0xA5.
- Back-to-back reads of addrs 0..15 after writing data=addr^0x5A -> 16 consecutive rsp_valid pulses, in order, with correct data.
- DEPTH=12, ADDR_W=4: write 0xFF to addr 13, then read addr 13 -> rsp_rdata=0x00; words 0..11 are unchanged.
- Assert rst_n low for 1 cycle while 2 reads are in flight (RD_LAT=4) -> no rsp_valid pulse; sweep restarts and init_done=0 for DEPTH cycles.
- MEM_PARITY_EN: write 0x3C with req_perr_inj=1 to addr 5, plain write to addr 6, then read both -> rsp_perr=1 for addr 5 and rsp_perr=0 for addr 6.

Source files
------------

// File: rtl/ias_param_memory.sv
// ----------------------------------------------------------------------------
// ias_param_memory
//
// Parametrised single-port data memory for the IAS datapath. After reset a
// hardware sweep writes zero into every word. While the sweep runs no request
// is accepted. Once it finishes, one request per cycle is accepted. Read data
// comes back on a fixed-latency response pipeline.
//
// Optional feature (compile-time macro MEM_PARITY_EN):
//   When defined, each word carries one extra even-parity bit. A write can
//   deliberately corrupt that bit through req_perr_inj. Each read response
//   reports a mismatch on rsp_perr. When undefined, req_perr_inj is ignored
//   and rsp_perr is tied to 0.
//
// Parameters:
//   DATA_W  data word width (1..64)
//   ADDR_W  address width
//   DEPTH   number of words (2..2**ADDR_W, any value in that range)
//   RD_LAT  cycles from read acceptance to response (1..4)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid     request present
//   req_ready     request accepted this cycle when req_valid is also high
//   req_we        1 = write, 0 = read
//   req_addr      word address (addresses >= DEPTH are out of range)
//   req_wdata     write data
//   req_perr_inj  store inverted parity on this write (parity build only)
//   rsp_valid     one-cycle pulse: rsp_rdata carries read data
//   rsp_rdata     read data; holds its last value between pulses
//   rsp_perr      parity mismatch on this response
//   init_done     clear sweep complete
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. The request fields are sampled only on that edge.
// The response channel has no backpressure: every accepted read produces
// exactly one rsp_valid pulse, in request order. Out-of-range reads are
// included; they return zero data.
// ----------------------------------------------------------------------------
module ias_param_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_perr_inj,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    output logic              init_done
);

`ifdef MEM_PARITY_EN
    localparam int SW = DATA_W + 1;   // {parity, data}
`else
    localparam int SW = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              run_q;

    logic              accept;
    logic              in_range;
    logic              rd_accept;

    // Storage array: not reset. The clear sweep defines its contents.
    logic [SW-1:0]     mem [0:DEPTH-1];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [SW-1:0]     mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [SW-1:0]     rd_word;

    // Read pipeline: stage 0 loads on the accepting edge. The last stage
    // drives the response outputs.
    logic [RD_LAT-1:0] pv;
    logic [DATA_W-1:0] pd [RD_LAT];

    assign req_ready = run_q;
    assign init_done = run_q;

    assign accept    = req_valid & req_ready;
    assign in_range  = (32'(req_addr) < 32'(DEPTH));
    assign rd_accept = accept & ~req_we;

    // ------------------------------------------------------------------
    // Control FSM: INIT sweeps the clear counter over every word, then
    // settles in RUN. Only reset returns it to INIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_cnt <= '0;
            run_q   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state <= RUN;
                        run_q <= 1'b1;
                    end
                end
                RUN: begin
                    run_q <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    run_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write port. The sweep owns the port during INIT. In RUN only
    // accepted, in-range writes reach the array.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;            // zero data has zero even parity
        end else if (accept && req_we && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = req_addr;
`ifdef MEM_PARITY_EN
            mem_wdata = {(^req_wdata) ^ req_perr_inj, req_wdata};
`else
            mem_wdata = req_wdata;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Out-of-range reads must not index past the array. They are replaced
    // by an all-zero word, which also has zero data and consistent parity.
    assign mem_raddr = in_range ? req_addr : '0;
    assign rd_word   = in_range ? mem[mem_raddr] : '0;

    // ------------------------------------------------------------------
    // Read response pipeline. Data registers load only behind a valid
    // bit. The final stage therefore keeps the last returned word between
    // pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= rd_accept;
            if (rd_accept) begin
                pd[0] <= rd_word[DATA_W-1:0];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    assign rsp_valid = pv[RD_LAT-1];
    assign rsp_rdata = pd[RD_LAT-1];

`ifdef MEM_PARITY_EN
    // The mismatch is resolved when the word leaves the array. The
    // reduction XOR covers data and stored parity together. Only the
    // resulting flag travels down the pipeline.
    logic pp [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pp[i] <= 1'b0;
            end
        end else begin
            if (rd_accept) begin
                pp[0] <= ^rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                if (pv[i-1]) begin
                    pp[i] <= pp[i-1];
                end
            end
        end
    end

    assign rsp_perr = pv[RD_LAT-1] & pp[RD_LAT-1];
`else
    logic unused_perr_inj;
    assign unused_perr_inj = req_perr_inj;
    assign rsp_perr        = 1'b0;
`endif

endmodule

// File: tb/tb_ias_param_memory.sv
module tb_ias_param_memory;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int RD_LAT = 3;
  localparam int EW     = 32 + 1 + DATA_W;   // {due_cycle, perr, data}

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_perr_inj;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_perr;
  logic              init_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: word contents and injected-parity flags per address.
  logic [DATA_W-1:0] m_data [0:DEPTH-1];
  logic              m_pinj [0:DEPTH-1];
  logic [EW-1:0]     exp_q[$];
  logic [EW-1:0]     e;
  logic [DATA_W-1:0] last_rdata = '0;

  ias_param_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_perr_inj (req_perr_inj),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_perr     (rsp_perr),
    .init_done    (init_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic req(input logic we, input int addr, input logic [DATA_W-1:0] d, input logic inj);
    logic perr_exp;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = ADDR_W'(addr);
    req_wdata    = d;
    req_perr_inj = inj;
    if (req_ready) begin
      if (we) begin
        if (addr < DEPTH) begin
          m_data[addr] = d;
          m_pinj[addr] = inj;
        end
      end else begin
        perr_exp = 1'b0;
        if (addr < DEPTH) begin
`ifdef MEM_PARITY_EN
          perr_exp = m_pinj[addr];
`endif
          exp_q.push_back({32'(cyc + RD_LAT), perr_exp, m_data[addr]});
        end else begin
          exp_q.push_back({32'(cyc + RD_LAT), 1'b0, {DATA_W{1'b0}}});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Reset pulse followed by n cycles of the clear sweep with req_valid held.
  task automatic sweep(input int n);
    rst_n = 1'b0;
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) begin
      m_data[a] = '0;
      m_pinj[a] = 1'b0;
    end
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_addr     = '0;
    req_wdata    = 8'hEE;
    req_perr_inj = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_perr", rsp_perr, 0);
    rst_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk("sweep_req_ready", req_ready, 0);
      chk("sweep_init_done", init_done, 0);
      @(negedge clk);
    end
    if (n == DEPTH) begin
      chk("sweep_end_req_ready", req_ready, 1);
      chk("sweep_end_init_done", init_done, 1);
    end
    req_valid = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rdata = '0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_valid", rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[DATA_W-1:0]);
        chk("rsp_perr", rsp_perr, e[DATA_W]);
        chk("rsp_cycle", cyc, e[EW-1:DATA_W+1]);
      end
      last_rdata = rsp_rdata;
    end else begin
      chk("rdata_hold", rsp_rdata, last_rdata);
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1:DATA_W+1]) <= cyc) begin
        chk("missing_rsp_valid", rsp_valid, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_perr_inj = 1'b0;
    @(negedge clk);

    // Clear sweep, then every address (including out-of-range) reads zero.
    sweep(DEPTH);
    for (int a = 0; a < 16; a++) req(1'b0, a, '0, 1'b0);
    idle(RD_LAT + 1);

    // Single write then read: exact latency.
    req(1'b1, 3, 8'hA5, 1'b0);
    req(1'b0, 3, '0, 1'b0);
    idle(RD_LAT + 1);

    // Pattern fill then back-to-back reads.
    for (int a = 0; a < 16; a++) req(1'b1, a, DATA_W'(a) ^ 8'h5A, 1'b0);
    for (int a = 0; a < 16; a++) req(1'b0, a, '0, 1'b0);
    idle(RD_LAT + 1);

    // Out-of-range write is dropped, read returns zero, in-range words intact.
    req(1'b1, 13, 8'hFF, 1'b0);
    req(1'b0, 13, '0, 1'b0);
    for (int a = 0; a < DEPTH; a++) req(1'b0, a, '0, 1'b0);
    idle(RD_LAT + 1);

    // Parity injection on addr 5, plain write on addr 6.
    req(1'b1, 5, 8'h3C, 1'b1);
    req(1'b1, 6, 8'h3C, 1'b0);
    req(1'b0, 5, '0, 1'b0);
    req(1'b0, 6, '0, 1'b0);
    idle(RD_LAT + 1);

    // Random mixed traffic with idle gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else req(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               DATA_W'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(RD_LAT + 1);

    // Reset with two reads in flight, then reset again in the middle of the sweep.
    req(1'b0, 1, '0, 1'b0);
    req(1'b0, 2, '0, 1'b0);
    sweep(5);
    sweep(DEPTH);
    for (int a = 0; a < 16; a++) req(1'b0, a, '0, 1'b0);
    idle(1);

    // Drain with a bounded wait.
    for (int k = 0; k < RD_LAT + 4 && exp_q.size() > 0; k++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
